// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: buffer entry, FSM state, reset PC.
package ifu_pkg;

  localparam logic [31:0] PC_INIT_DEFAULT = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } state_t;

endpackage

// File: rtl/ifu_fifo.sv
// Fetch buffer: power-of-two FIFO of fetch entries with flush and a zeroed head when empty.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               pushEntry,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       headValid,
  output fetch_entry_t               head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t            mem [DEPTH];
  logic [PTR_W-1:0]        wrPtr;
  logic [PTR_W-1:0]        rdPtr;

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= pushEntry;
    end
  end

  // Pointers and occupancy; flush empties the buffer including a same-cycle pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign headValid = (count != '0);
  assign head      = headValid ? mem[rdPtr] : '0;

endmodule

// File: rtl/ifu_ctrl.sv
// Instruction fetch control: PC sequencing, redirect handling, fetch buffer.
// Optional IFU_ADEL_EN: flags misaligned / out-of-IM fetch addresses and halts in ERR.
module ifu_ctrl
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_INIT  = PC_INIT_DEFAULT,
  parameter int unsigned IM_WORDS = 4096,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [32:0] PC_END = {1'b0, PC_INIT} + (33'(IM_WORDS) << 2);
`ifdef IFU_ADEL_EN
  localparam bit ADEL_EN = 1'b1;
`else
  localparam bit ADEL_EN = 1'b0;
`endif

  state_t             state;
  state_t             stateNext;
  logic [31:0]        pc;
  logic [31:0]        pcNext;
  logic               push;
  logic               pop;
  logic               pushSlot;
  logic               adel;
  logic               headValid;
  logic [CNT_W-1:0]   count;
  fetch_entry_t       pushEntry;
  fetch_entry_t       head;

  assign pop      = headValid && out_ready;
  assign pushSlot = (state == RUN) && !redirect_valid &&
                    ((count < CNT_W'(DEPTH)) || pop);
  assign adel     = ADEL_EN && ((pc[1:0] != 2'b00) || (pc < PC_INIT) ||
                                ({1'b0, pc} >= PC_END));

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= PC_INIT;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
    end
  end

  // Next state: redirect always resumes fetching; a faulting fetch halts it.
  always_comb begin
    stateNext = state;
    if (redirect_valid) begin
      stateNext = RUN;
    end else if (pushSlot && adel) begin
      stateNext = ERR;
    end
  end

  // Push decision, pushed entry and next PC.
  always_comb begin
    push      = 1'b0;
    pushEntry = '0;
    pcNext    = pc;
    if (redirect_valid) begin
      pcNext = redirect_pc;
    end else if (pushSlot) begin
      push         = 1'b1;
      pushEntry.pc = pc;
      if (adel) begin
        pushEntry.exc = 1'b1;
      end else begin
        pushEntry.instr = im_instr;
        pcNext          = pc + 32'd4;
      end
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .pushEntry (pushEntry),
    .count     (count),
    .headValid (headValid),
    .head      (head)
  );

  assign im_pc     = pc;
  assign out_valid = headValid;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_exc   = head.exc;

endmodule

// File: doc/ifu_ctrl.md
IFU_CTRL -- requirements
Module: ifu_ctrl

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_3000, meaning the reset PC and IM base address.
REQ-002 SHALL have parameter IM_WORDS, default 4096, meaning the number of IM words addressable from PC_INIT.
REQ-003 SHALL have parameter DEPTH, default 2, meaning the number of fetch buffer entries (power of two, ≥2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port im_pc, output, 32 bits: fetch address driven to the combinational IM.
REQ-007 SHALL have port im_instr, input, 32 bits: IM read data for im_pc, valid in the same cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: the buffer head is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: decode accepts the head.
REQ-010 SHALL have port out_pc, output, 32 bits: PC of the head entry.
REQ-011 SHALL have port out_instr, output, 32 bits: instruction of the head entry.
REQ-012 SHALL have port out_exc, output, 1 bit: the head entry carries a fetch address error.
REQ-013 SHALL have port redirect_valid, input, 1 bit: branch/jump/exception redirect request.
REQ-014 SHALL have port redirect_pc, input, 32 bits: redirect target address.

Function
REQ-015 SHALL complete a pop only in a cycle where out_valid && out_ready.
REQ-016 SHALL push {im_pc, im_instr, exc=0} at the clock edge when state==RUN && !redirect_valid && (count<DEPTH || pop), then set pc <= pc+4, wrapping modulo 2^32.
REQ-017 SHALL make a pushed entry visible on out_* in the cycle after the push, so first-fetch latency is 1 cycle.
REQ-018 SHALL accept a push and a pop in the same cycle when full, leaving count unchanged (full throughput).
REQ-019 SHALL hold im_pc equal to the internal pc register at all times.
REQ-020 SHALL hold out_valid at 0 when empty, with out_pc, out_instr and out_exc at 0.
REQ-021 SHALL, on redirect_valid, flush all entries at the edge, including any head popped in that cycle (pop is honoured, not re-presented), set pc <= redirect_pc, skip the push, and force state to RUN.
REQ-022 SHALL give redirect priority over push, full, and ERR.
REQ-023 SHALL deliver the redirect target on out_* two cycles after the redirect cycle.
REQ-024 SHALL implement two FSM states: RUN (fetching) and ERR (fetch halted, entered only per REQ-029); ERR exits only via redirect or reset.
REQ-025 SHALL keep the buffer in FIFO order, with no reordering or duplication.

Reset
REQ-026 SHALL, on reset, set pc=PC_INIT, count=0, read/write pointers=0, state=RUN, out_valid=0, and out_pc/out_instr/out_exc=0.
REQ-027 SHALL give reset priority over redirect and all handshakes; reset mid-stream discards all entries.
REQ-028 SHALL present the PC_INIT entry on out_* in the second cycle after reset deasserts.

Configuration
REQ-029 SHALL, with IFU_ADEL_EN defined, treat a pc that is misaligned (pc[1:0]!=0) or outside [PC_INIT, PC_INIT+4*IM_WORDS) as an address error: at the push slot, push {pc, 32'h0, exc=1}, do not advance pc, and go to ERR.
REQ-030 SHALL, without IFU_ADEL_EN, omit the range check, tie out_exc to 0, never enter ERR, and fetch any pc unchecked.

Structure
REQ-031 SHALL place the fetch_entry_t struct {pc, instr, exc}, the state enum {RUN, ERR}, and the default PC_INIT in shared package ifu_pkg.
REQ-032 SHALL implement the buffer as sub-module ifu_fifo, parameterised by DEPTH and carrying fetch_entry_t, with push, pop, flush, count, and head ports; the FSM and pc logic live in ifu_ctrl.

Verification
REQ-033 SHALL verify: reset, out_ready=1 -> out_pc sequence 0x3000, 0x3004, 0x3008, one per cycle, with out_valid first seen in cycle 2.
REQ-034 SHALL verify: out_ready=0 for 5 cycles -> count saturates at 2, pc holds 0x3008, head stays 0x3000; out_ready=1 -> heads 0x3000, 0x3004, 0x3008 with no gap.
REQ-035 SHALL verify: redirect_valid with redirect_pc=0x3100 while full, concurrent with a pop -> buffer empty next cycle, out_pc=0x3100 two cycles later, with no 0x3004 ever reappearing.
REQ-036 SHALL verify, with IFU_ADEL_EN: redirect to 0x3102 -> one entry {0x3102, 0, exc=1}, fetching stops in ERR; redirect to 0x3000 -> normal flow resumes.
REQ-037 SHALL verify, with IFU_ADEL_EN: sequential fetch reaching 0x7000 -> exc=1 entry at 0x7000; without IFU_ADEL_EN -> 0x7000 is fetched with exc=0.
REQ-038 SHALL verify: reset asserted while 2 entries are valid -> out_valid=0 next cycle, and the sequence restarts at 0x3000.
